// File: rtl/cpu_bus_tracer.sv
// Bus-cycle trace buffer: captures qualified CPU cycles around an address trigger and
// streams the retained window out over valid/ready. Optional timestamp field: TRACE_TIMESTAMP_EN.
module cpu_bus_tracer #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DEPTH    = 64,
   parameter int unsigned PRE_TRIG = 16,
`ifdef TRACE_TIMESTAMP_EN
   localparam int unsigned TS_W    = 16,
`else
   localparam int unsigned TS_W    = 0,
`endif
   localparam int unsigned ENTRY_W = TS_W + 1 + ADDR_W + DATA_W,
   localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               sample_en,
   input  logic [ADDR_W-1:0]  bus_addr,
   input  logic [DATA_W-1:0]  bus_data,
   input  logic               bus_rd,
   input  logic               bus_wr,
   input  logic               arm,
   input  logic               abort,
   input  logic [ADDR_W-1:0]  trig_addr,
   input  logic [ADDR_W-1:0]  trig_mask,
   input  logic [1:0]         trig_rw,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic [ENTRY_W-1:0] rd_data,
   output logic [CNT_W-1:0]   count,
   output logic [2:0]         state,
   output logic               triggered
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned POST_N = DEPTH - PRE_TRIG - 1;
   localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] POST_LOAD = PTR_W'(POST_N);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StArmed   = 3'd1,
      StPost    = 3'd2,
      StDone    = 3'd3,
      StReadout = 3'd4
   } state_e;

   state_e             st_q;
   logic [PTR_W-1:0]   wptr_q, rptr_q, post_cnt_q;
   logic [CNT_W-1:0]   count_q;
   logic               triggered_q, rd_valid_q;
   logic [ENTRY_W-1:0] rd_data_q;
   logic [ENTRY_W-1:0] mem [DEPTH];

   logic               qual, is_wr, rw_match, trig_hit, capturing, store;
   logic [ENTRY_W-1:0] entry;
   logic [PTR_W-1:0]   first_ptr, next_ptr;

   always_comb begin
      qual      = sample_en & (bus_rd | bus_wr);
      is_wr     = bus_wr;
      rw_match  = (trig_rw[0] & ~is_wr) | (trig_rw[1] & is_wr);
      trig_hit  = qual & rw_match & (((bus_addr ^ trig_addr) & trig_mask) == '0);
      capturing = (st_q == StArmed) || (st_q == StPost);
      store     = capturing & qual & ~abort;
      // A full buffer has wrapped, so the oldest entry sits at the write pointer.
      first_ptr = (count_q == FULL) ? wptr_q : '0;
      next_ptr  = rptr_q + PTR_W'(1);
   end

`ifdef TRACE_TIMESTAMP_EN
   logic [15:0] ts_q;
   assign entry = {ts_q, is_wr, bus_addr, bus_data};
`else
   assign entry = {is_wr, bus_addr, bus_data};
`endif

   always_ff @(posedge clk) begin
      if (store) mem[wptr_q] <= entry;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         st_q        <= StIdle;
         wptr_q      <= '0;
         rptr_q      <= '0;
         post_cnt_q  <= '0;
         count_q     <= '0;
         triggered_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
`ifdef TRACE_TIMESTAMP_EN
         ts_q        <= '0;
`endif
      end else begin
`ifdef TRACE_TIMESTAMP_EN
         if (st_q == StIdle && arm) ts_q <= '0;
         else if (capturing)        ts_q <= ts_q + 16'd1;
`endif
         if (abort) begin
            st_q       <= StIdle;
            rd_valid_q <= 1'b0;
         end else begin
            unique case (st_q)
               StIdle: begin
                  if (arm) begin
                     st_q        <= StArmed;
                     wptr_q      <= '0;
                     count_q     <= '0;
                     post_cnt_q  <= '0;
                     triggered_q <= 1'b0;
                  end
               end
               StArmed: begin
                  if (store) begin
                     wptr_q <= wptr_q + PTR_W'(1);
                     if (count_q != FULL) count_q <= count_q + CNT_W'(1);
                     if (trig_hit) begin
                        triggered_q <= 1'b1;
                        post_cnt_q  <= POST_LOAD;
                        st_q        <= (POST_N == 0) ? StDone : StPost;
                     end
                  end
               end
               StPost: begin
                  if (store) begin
                     wptr_q     <= wptr_q + PTR_W'(1);
                     if (count_q != FULL) count_q <= count_q + CNT_W'(1);
                     post_cnt_q <= post_cnt_q - PTR_W'(1);
                     if (post_cnt_q == PTR_W'(1)) st_q <= StDone;
                  end
               end
               StDone: begin
                  rptr_q    <= first_ptr;
                  rd_data_q <= mem[first_ptr];
                  if (count_q == '0) begin
                     st_q <= StIdle;
                  end else begin
                     st_q       <= StReadout;
                     rd_valid_q <= 1'b1;
                  end
               end
               StReadout: begin
                  if (rd_valid_q && rd_ready) begin
                     count_q <= count_q - CNT_W'(1);
                     if (count_q == CNT_W'(1)) begin
                        rd_valid_q <= 1'b0;
                        st_q       <= StIdle;
                     end else begin
                        rptr_q    <= next_ptr;
                        rd_data_q <= mem[next_ptr];
                     end
                  end
               end
               default: st_q <= StIdle;
            endcase
         end
      end
   end

   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign count     = count_q;
   assign state     = st_q;
   assign triggered = triggered_q;

endmodule

// File: tb/tb_cpu_bus_tracer.sv
// Self-checking bench for cpu_bus_tracer (DEPTH=16, PRE_TRIG=4) against a sample-queue model.
module tb_cpu_bus_tracer;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam int DEPTH = 16;
   localparam int PRE = 4;
`ifdef TRACE_TIMESTAMP_EN
   localparam int EW = 17 + AW + DW;
`else
   localparam int EW = 1 + AW + DW;
`endif
   localparam int CW = $clog2(DEPTH) + 1;

   logic          clk = 0, reset_n = 0, sample_en = 0, bus_rd = 0, bus_wr = 0;
   logic          arm = 0, abort = 0, rd_ready = 0;
   logic [AW-1:0] bus_addr = '0, trig_addr = '0, trig_mask = '0;
   logic [DW-1:0] bus_data = '0;
   logic [1:0]    trig_rw = 2'b00;
   logic          rd_valid, triggered;
   logic [EW-1:0] rd_data;
   logic [CW-1:0] count;
   logic [2:0]    state;

   cpu_bus_tracer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .PRE_TRIG(PRE)) dut (
      .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .bus_addr(bus_addr),
      .bus_data(bus_data), .bus_rd(bus_rd), .bus_wr(bus_wr), .arm(arm), .abort(abort),
      .trig_addr(trig_addr), .trig_mask(trig_mask), .trig_rw(trig_rw), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .rd_data(rd_data), .count(count), .state(state),
      .triggered(triggered)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   // Model: every stored sample of the current capture, oldest first.
   logic [AW+DW:0] exp_q[$];
   logic [AW-1:0]  got_addr[$];
   int m_phase;  // 0 idle, 1 pre-trigger, 2 post-trigger, 3 complete
   int m_post;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [AW-1:0] a, input logic rd, input logic wr);
      logic [DW-1:0] d;
      logic          w;
      d = DW'($urandom);
      @(negedge clk);
      sample_en = en; bus_addr = a; bus_data = d; bus_rd = rd; bus_wr = wr;
      w = wr;
      if ((m_phase == 1 || m_phase == 2) && en && (rd || wr)) begin
         exp_q.push_back({w, a, d});
         if (m_phase == 2) begin
            m_post--;
            if (m_post == 0) m_phase = 3;
         end else if (((a ^ trig_addr) & trig_mask) == 0 &&
                      ((trig_rw[0] && !w) || (trig_rw[1] && w))) begin
            m_post  = DEPTH - PRE - 1;
            m_phase = (m_post == 0) ? 3 : 2;
         end
      end
   endtask

   task automatic do_arm();
      @(negedge clk);
      sample_en = 0; arm = 1;
      exp_q.delete(); got_addr.delete();
      m_phase = 1;
      @(negedge clk);
      arm = 0;
   endtask

   task automatic do_abort();
      @(negedge clk);
      abort = 1; sample_en = 0;
      @(negedge clk);
      abort = 0; m_phase = 0;
   endtask

   task automatic post_done();
      while (exp_q.size() > DEPTH) void'(exp_q.pop_front());
      @(negedge clk);
      sample_en = 0; bus_rd = 0; bus_wr = 0;
      check("done_state", state, 3);
      check("done_valid", rd_valid, 0);
      check("done_count", count, exp_q.size());
      check("done_triggered", triggered, 1);
      @(negedge clk);
      check("readout_valid", rd_valid, 1);
      check("readout_state", state, 4);
   endtask

   // mode 0: ready held high, 1: toggle 1/0, 2: random. abort_left >= 0 aborts at that many left.
   task automatic readout(input int mode, input int abort_left);
      int idx = 0;
      logic stalled = 0;
      logic [EW-1:0] prev = '0;
      logic rdy;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (!rd_valid) break;
         if (idx < exp_q.size()) check("entry", rd_data[AW+DW:0], exp_q[idx]);
         else check("entry_extra", idx, exp_q.size());
         if (stalled) check("stall_stable", rd_data, prev);
         if (abort_left >= 0 && exp_q.size() - idx == abort_left) begin
            abort = 1; rd_ready = 1;
            @(negedge clk);
            abort = 0; rd_ready = 0; m_phase = 0;
            check("abort_state", state, 0);
            check("abort_valid", rd_valid, 0);
            return;
         end
         case (mode)
            0:       rdy = 1;
            1:       rdy = (cyc % 2) == 0;
            default: rdy = $urandom_range(0, 1) == 1;
         endcase
         rd_ready = rdy;
         prev = rd_data;
         stalled = !rdy;
         if (rdy) begin
            got_addr.push_back(rd_data[AW+DW-1:DW]);
            idx++;
         end
         @(negedge clk);
      end
      rd_ready = 0;
      check("readout_total", idx, exp_q.size());
      check("readout_end_state", state, 0);
      check("readout_end_valid", rd_valid, 0);
      m_phase = 0;
   endtask

   task automatic stream_reads();
      trig_addr = 16'h0210; trig_mask = 16'hFFFF; trig_rw = 2'b01;
      do_arm();
      for (int a = 16'h0200; a <= 16'h0230 && m_phase != 3; a++) drive(1, AW'(a), 1, 0);
      post_done();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      m_phase = 0;
      // Reset with arm held high
      arm = 1;
      repeat (3) @(negedge clk);
      check("rst_state", state, 0);
      check("rst_valid", rd_valid, 0);
      check("rst_count", count, 0);
      check("rst_triggered", triggered, 0);
      check("rst_data", rd_data, 0);
      reset_n = 1; arm = 0;
      @(negedge clk);
      check("post_rst_state", state, 0);
      do_arm();
      check("arm_state", state, 1);
      do_abort();
      check("abort_idle", state, 0);

      // Read stream with trigger at 0x0210
      stream_reads();
      check("stream_count", count, 16);
      readout(0, -1);
      check("stream_n", got_addr.size(), 16);
      if (got_addr.size() == 16) begin
         check("stream_first", got_addr[0], 16'h020C);
         check("stream_e4", got_addr[4], 16'h0210);
         check("stream_last", got_addr[15], 16'h021B);
      end

      // Stack-push write trigger on the 2nd bus cycle
      trig_addr = 16'h01FD; trig_mask = 16'hFFFF; trig_rw = 2'b10;
      do_arm();
      drive(1, 16'hFFFC, 1, 0);
      drive(1, 16'h01FD, 0, 1);
      while (m_phase == 2) drive(1, AW'(16'h0100 | $urandom_range(0, 255)), 1, $urandom_range(0, 1) == 1);
      post_done();
      check("stack_count", count, 13);
      readout(1, -1);
      if (got_addr.size() > 0) check("stack_first", got_addr[0], 16'hFFFC);
      else check("stack_first_missing", got_addr.size(), 13);

      // sample_en low for 5 cycles during POST
      trig_addr = 16'h0300; trig_mask = 16'hFFFF; trig_rw = 2'b11;
      do_arm();
      for (int a = 16'h02F8; a <= 16'h0300; a++) drive(1, AW'(a), 1, 0);
      for (int i = 0; i < 3; i++) drive(1, AW'(16'h0301 + i), 1, 0);
      for (int i = 0; i < 5; i++) drive(0, 16'hDEAD, 1, 0);
      for (int i = 3; i < 20 && m_phase == 2; i++) drive(1, AW'(16'h0301 + i), 1, 0);
      post_done();
      check("gap_count", count, 16);
      readout(2, -1);
      check("gap_n", got_addr.size(), 16);
      if (got_addr.size() == 16) begin
         check("gap_e4", got_addr[4], 16'h0300);
         check("gap_e7", got_addr[7], 16'h0303);
      end

      // Abort during readout with 6 entries left, then re-arm
      stream_reads();
      readout(0, 6);
      do_arm();
      check("rearm_state", state, 1);
      check("rearm_count", count, 0);
      check("rearm_triggered", triggered, 0);
      // trig_rw=00 never triggers
      trig_rw = 2'b00; trig_mask = 16'h0000;
      for (int i = 0; i < 20; i++) drive(1, AW'($urandom), 1, $urandom_range(0, 1) == 1);
      @(negedge clk);
      check("never_state", state, 1);
      check("never_triggered", triggered, 0);
      check("never_count", count, 16);
      do_abort();

      // Randomized captures
      for (int r = 0; r < 4; r++) begin
         trig_addr = AW'($urandom);
         trig_mask = AW'($urandom_range(1, 7));
         trig_rw = 2'($urandom_range(1, 3));
         do_arm();
         for (int i = 0; i < 400 && m_phase != 3; i++)
            drive($urandom_range(0, 3) != 0, AW'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1);
         if (m_phase == 3) begin
            post_done();
            readout(2, -1);
         end else begin
            check("rand_trigger", m_phase, 3);
            do_abort();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
